etherneco_synctimer_slave_cmd: RTL and testbench

- Slave-node consumer of the synctimer command packet that the master emits on its command stream.
- Parses the command byte, the 64-bit master timestamp and this node's offset field from the received payload, and computes the local-vs-master time error.
- Steers the local synctimer timer: an absolute load on a renew command, or a bounded burst of single-tick adjust handshakes on a correct command.
- Sits between the etherneco packet receiver and the node's local synctimer timer instance.

---
 rtl/etherneco_synctimer_pkg.sv | 26 ++
 rtl/etherneco_synctimer_cmd_parser.sv | 67 ++++++
 rtl/etherneco_synctimer_slave_cmd.sv | 187 ++++++++++++++++++
 tb/tb_etherneco_synctimer_slave_cmd.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/etherneco_synctimer_pkg.sv
// etherneco_synctimer_pkg
// Definitions shared by the synctimer command builder (master side) and the
// command consumer (slave side): payload field layout, command bit indices
// and the receive-latency cycle-to-time conversion.
package etherneco_synctimer_pkg;

  // Timestamp field: 8 bytes, element 0 is the least significant byte.
  typedef logic [7:0][7:0] t_time_pkt;
  // One node's offset field: 4 bytes, element 0 is the least significant byte.
  typedef logic [3:0][7:0] t_offset_pkt;

  localparam int CMD_POS_CMD    = 0;
  localparam int CMD_POS_TIME   = 1;
  localparam int CMD_POS_OFFSET = 9;
  localparam int OFFSET_STRIDE  = 4;

  localparam int CMD_BIT_CORRECT = 0;
  localparam int CMD_BIT_RENEW   = 1;

  // Converts a cycle count into timer units, truncating toward zero.
  function automatic int cycle_to_time(input int numerator, input int denominator,
                                       input int cycles);
    return (numerator * cycles) / denominator;
  endfunction

endpackage

// File: rtl/etherneco_synctimer_cmd_parser.sv
// etherneco_synctimer_cmd_parser
// Captures the command bits, the master timestamp and this node's offset
// field out of the received payload byte stream.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   clear                drop all captured fields (new packet start)
//   capture              accept the current payload byte
//   node_id              offset field index for this node
//   length               payload length minus 1
//   pos, data            payload byte index and value
//   cmd_renew/correct    captured command bits
//   timestamp, offset    captured fields (offset zero-extended low bits)
//   length_ok            packet is long enough and node_id is in range
module etherneco_synctimer_cmd_parser
  import etherneco_synctimer_pkg::*;
#(
  parameter int MAX_NODES    = 2,
  parameter int OFFSET_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    capture,
  input  logic [7:0]              node_id,
  input  logic [15:0]             length,
  input  logic [15:0]             pos,
  input  logic [7:0]              data,
  output logic                    cmd_renew,
  output logic                    cmd_correct,
  output logic [63:0]             timestamp,
  output logic [OFFSET_WIDTH-1:0] offset,
  output logic                    length_ok
);

  t_time_pkt   time_bytes;
  t_offset_pkt offset_bytes;
  logic [1:0]  cmd_bits;
  logic [15:0] off_base;
  logic [15:0] off_last;

  assign off_base = 16'(CMD_POS_OFFSET) + 16'(OFFSET_STRIDE) * {8'd0, node_id};
  assign off_last = off_base + 16'(OFFSET_STRIDE - 1);

  // The last byte this node needs is the top byte of its own offset field.
  assign length_ok = (length >= off_last) && (int'(node_id) < MAX_NODES);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cmd_bits     <= '0;
      time_bytes   <= '0;
      offset_bytes <= '0;
    end else if (capture) begin
      if (pos == 16'(CMD_POS_CMD))
        cmd_bits <= data[1:0];
      if (pos >= 16'(CMD_POS_TIME) && pos < 16'(CMD_POS_TIME + 8))
        time_bytes[3'(pos - 16'(CMD_POS_TIME))] <= data;
      if (pos >= off_base && pos <= off_last)
        offset_bytes[2'(pos - off_base)] <= data;
    end
  end

  assign cmd_renew   = cmd_bits[CMD_BIT_RENEW];
  assign cmd_correct = cmd_bits[CMD_BIT_CORRECT];
  assign timestamp   = time_bytes;
  assign offset      = OFFSET_WIDTH'(offset_bytes);

endmodule

// File: rtl/etherneco_synctimer_slave_cmd.sv
// etherneco_synctimer_slave_cmd
// Slave-side consumer of the synctimer command packet. Computes the
// master-minus-local time error and steers the local timer either with an
// absolute load (renew) or a bounded burst of single-tick adjusts (correct).
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   node_id, current_time        node index, local timer value
//   cmd_rx_*, cmd_payload_*      packet framing and payload byte stream
//   set_time, set_valid          absolute timer load
//   adjust_sign/valid/ready      single-tick adjust handshake
//   time_error, time_error_valid saturated signed error and update pulse
//   drop_count                   saturating dropped-packet counter
module etherneco_synctimer_slave_cmd
  import etherneco_synctimer_pkg::*;
#(
  parameter int TIMER_WIDTH       = 64,
  parameter int NUMERATOR         = 10,
  parameter int DENOMINATOR       = 3,
  parameter int MAX_NODES         = 2,
  parameter int OFFSET_WIDTH      = 24,
  parameter int ERROR_WIDTH       = 32,
  parameter int RX_LATENCY_CYCLES = 2,
  parameter int ADJUST_MAX        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             node_id,
  input  logic [TIMER_WIDTH-1:0] current_time,
  input  logic                   cmd_rx_start,
  input  logic                   cmd_rx_end,
  input  logic                   cmd_rx_error,
  input  logic [15:0]            cmd_rx_length,
  input  logic [15:0]            cmd_payload_pos,
  input  logic [7:0]             cmd_payload_data,
  input  logic                   cmd_payload_valid,
  output logic [TIMER_WIDTH-1:0] set_time,
  output logic                   set_valid,
  output logic                   adjust_sign,
  output logic                   adjust_valid,
  input  logic                   adjust_ready,
  output logic [ERROR_WIDTH-1:0] time_error,
  output logic                   time_error_valid,
  output logic [15:0]            drop_count
);

  localparam int LATENCY_TIME = cycle_to_time(NUMERATOR, DENOMINATOR, RX_LATENCY_CYCLES);
  localparam int CNT_W        = $clog2(ADJUST_MAX + 1);
  localparam logic [TIMER_WIDTH-1:0] ERR_MAX =
    {{(TIMER_WIDTH - ERROR_WIDTH + 1){1'b0}}, {(ERROR_WIDTH - 1){1'b1}}};
  localparam logic [TIMER_WIDTH-1:0] ERR_MIN =
    {{(TIMER_WIDTH - ERROR_WIDTH + 1){1'b1}}, {(ERROR_WIDTH - 1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE, ST_RECV, ST_CALC_SUM, ST_CALC_DIFF, ST_SET, ST_ADJUST
  } t_state;

  t_state state, state_next;

  logic                    cmd_renew, cmd_correct, length_ok;
  logic [63:0]             timestamp;
  logic [OFFSET_WIDTH-1:0] offset;
  logic                    capture_start, do_drop, drop_pkt;
  logic [TIMER_WIDTH-1:0]  local_start, sum, diff;
  logic [ERROR_WIDTH-1:0]  err_sat, err_mag;
  logic [CNT_W-1:0]        adjust_count, adjust_load;

  etherneco_synctimer_cmd_parser #(
    .MAX_NODES    (MAX_NODES),
    .OFFSET_WIDTH (OFFSET_WIDTH)
  ) u_parser (
    .clk         (clk),
    .reset       (reset),
    .clear       (capture_start),
    .capture     (state == ST_RECV && cmd_payload_valid),
    .node_id     (node_id),
    .length      (cmd_rx_length),
    .pos         (cmd_payload_pos),
    .data        (cmd_payload_data),
    .cmd_renew   (cmd_renew),
    .cmd_correct (cmd_correct),
    .timestamp   (timestamp),
    .offset      (offset),
    .length_ok   (length_ok)
  );

  assign drop_pkt = cmd_rx_error || !length_ok || !(cmd_renew || cmd_correct);

  // Error arithmetic: diff wraps at the timer width; saturation preserves sign.
  assign diff = sum - local_start;
  always_comb begin
    if ($signed(diff) > $signed(ERR_MAX))      err_sat = ERR_MAX[ERROR_WIDTH-1:0];
    else if ($signed(diff) < $signed(ERR_MIN)) err_sat = ERR_MIN[ERROR_WIDTH-1:0];
    else                                       err_sat = diff[ERROR_WIDTH-1:0];
  end
  // The negated minimum stays representable as an unsigned magnitude.
  assign err_mag     = err_sat[ERROR_WIDTH-1] ? -err_sat : err_sat;
  assign adjust_load = (err_mag > ERROR_WIDTH'(ADJUST_MAX)) ? CNT_W'(ADJUST_MAX)
                                                            : CNT_W'(err_mag);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // A start pulse outside IDLE/RECV cannot be served and counts as a drop.
  always_comb begin
    state_next    = state;
    capture_start = 1'b0;
    do_drop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_rx_start) begin
          capture_start = 1'b1;
          state_next    = ST_RECV;
        end
      end
      ST_RECV: begin
        if (cmd_rx_start) begin
          capture_start = 1'b1;
        end else if (cmd_rx_end) begin
          if (drop_pkt) begin
            do_drop    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            state_next = ST_CALC_SUM;
          end
        end
      end
      ST_CALC_SUM: begin
        do_drop    = cmd_rx_start;
        state_next = ST_CALC_DIFF;
      end
      ST_CALC_DIFF: begin
        do_drop = cmd_rx_start;
        if (cmd_renew)        state_next = ST_SET;
        else if (diff == '0)  state_next = ST_IDLE;
        else                  state_next = ST_ADJUST;
      end
      ST_SET: begin
        do_drop    = cmd_rx_start;
        state_next = ST_IDLE;
      end
      ST_ADJUST: begin
        do_drop = cmd_rx_start;
        if (adjust_ready && adjust_count == CNT_W'(1)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      local_start      <= '0;
      sum              <= '0;
      set_time         <= '0;
      adjust_sign      <= 1'b0;
      adjust_count     <= '0;
      time_error       <= '0;
      time_error_valid <= 1'b0;
      drop_count       <= '0;
    end else begin
      time_error_valid <= 1'b0;
      if (capture_start)
        local_start <= current_time;
      if (do_drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
      if (state == ST_CALC_SUM)
        sum <= TIMER_WIDTH'(timestamp) + TIMER_WIDTH'(offset) + TIMER_WIDTH'(LATENCY_TIME);
      if (state == ST_CALC_DIFF) begin
        time_error       <= err_sat;
        time_error_valid <= 1'b1;
        if (cmd_renew) begin
          set_time <= current_time + diff;
        end else begin
          adjust_count <= adjust_load;
          adjust_sign  <= diff[TIMER_WIDTH-1];
        end
      end
      if (state == ST_ADJUST && adjust_ready)
        adjust_count <= adjust_count - CNT_W'(1);
    end
  end

  assign set_valid    = (state == ST_SET);
  assign adjust_valid = (state == ST_ADJUST);

endmodule

// File: tb/tb_etherneco_synctimer_slave_cmd.sv
// tb_etherneco_synctimer_slave_cmd
// Directed scenarios followed by randomized packets, each checked against a
// behavioural model of the expected error, load value and adjust burst.
module tb_etherneco_synctimer_slave_cmd;

  localparam longint LATENCY = 20;  // 10 * 2 / 1

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  node_id;
  logic [63:0] current_time;
  logic        cmd_rx_start, cmd_rx_end, cmd_rx_error;
  logic [15:0] cmd_rx_length, cmd_payload_pos;
  logic [7:0]  cmd_payload_data;
  logic        cmd_payload_valid;
  logic [63:0] set_time;
  logic        set_valid, adjust_sign, adjust_valid, adjust_ready;
  logic [31:0] time_error;
  logic        time_error_valid;
  logic [15:0] drop_count;

  int checks_total  = 0;
  int checks_passed = 0;
  int drop_model    = 0;

  etherneco_synctimer_slave_cmd #(
    .TIMER_WIDTH(64), .NUMERATOR(10), .DENOMINATOR(1), .MAX_NODES(2),
    .OFFSET_WIDTH(24), .ERROR_WIDTH(32), .RX_LATENCY_CYCLES(2), .ADJUST_MAX(16)
  ) dut (
    .clk(clk), .reset(reset), .node_id(node_id), .current_time(current_time),
    .cmd_rx_start(cmd_rx_start), .cmd_rx_end(cmd_rx_end), .cmd_rx_error(cmd_rx_error),
    .cmd_rx_length(cmd_rx_length), .cmd_payload_pos(cmd_payload_pos),
    .cmd_payload_data(cmd_payload_data), .cmd_payload_valid(cmd_payload_valid),
    .set_time(set_time), .set_valid(set_valid), .adjust_sign(adjust_sign),
    .adjust_valid(adjust_valid), .adjust_ready(adjust_ready),
    .time_error(time_error), .time_error_valid(time_error_valid),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Advances one clock; inputs set afterwards belong to the new cycle and
  // outputs read afterwards are that cycle's values.
  task automatic step();
    @(posedge clk);
    #1;
    cmd_rx_start      = 1'b0;
    cmd_rx_end        = 1'b0;
    cmd_rx_error      = 1'b0;
    cmd_payload_valid = 1'b0;
    adjust_ready      = 1'b0;
  endtask

  task automatic applyStimulus(input int node, input logic [7:0] cmd,
                               input logic [63:0] ts, input logic [31:0] off_field,
                               input int plen, input bit err,
                               input logic [63:0] ls, input logic [63:0] ct2,
                               input bit restart, input bit busy, input bit abort_reset);
    logic [7:0]  pay [0:31];
    logic [63:0] diff;
    longint      sd;
    logic [31:0] exp_err;
    bit          drop, renew, adj, gap, was_valid;
    int          n, hs;

    // Reference model: plain arithmetic from the field definitions.
    drop  = err || (plen < 12 + 4 * node) || (node >= 2) || (cmd[1:0] == 2'b00);
    renew = cmd[1];
    diff  = ts + {40'd0, off_field[23:0]} + 64'(LATENCY) - ls;
    sd    = longint'(diff);
    if (sd > 64'sd2147483647)       exp_err = 32'h7FFF_FFFF;
    else if (sd < -64'sd2147483648) exp_err = 32'h8000_0000;
    else                            exp_err = 32'(sd);
    if (sd > 16 || sd < -16) n = 16;
    else                     n = (sd < 0) ? int'(-sd) : int'(sd);
    adj = !drop && !renew && (sd != 0);

    for (int i = 0; i < 32; i++) pay[i] = 8'($urandom);
    pay[0] = cmd;
    for (int k = 0; k < 8; k++) pay[1 + k] = ts[8 * k +: 8];
    for (int j = 0; j < 4; j++) pay[9 + 4 * node + j] = off_field[8 * j +: 8];

    node_id = 8'(node);
    if (restart) begin
      cmd_rx_start = 1'b1;
      current_time = ls + 64'($urandom_range(1, 500));
      step();
      for (int p = 0; p < 3; p++) begin
        cmd_payload_valid = 1'b1;
        cmd_payload_pos   = 16'(p);
        cmd_payload_data  = 8'($urandom);
        step();
      end
    end
    cmd_rx_start = 1'b1;
    current_time = ls;
    step();
    for (int p = 0; p <= plen; p++) begin
      cmd_payload_valid = 1'b1;
      cmd_payload_pos   = 16'(p);
      cmd_payload_data  = pay[p];
      current_time      = {$urandom, $urandom};
      step();
    end
    cmd_rx_end    = 1'b1;
    cmd_rx_error  = err;
    cmd_rx_length = 16'(plen);
    step();
    if (drop) drop_model++;
    if (busy && !drop && !adj) begin
      cmd_rx_start = 1'b1;
      drop_model++;
    end
    step();
    current_time = ct2;
    step();

    checkOutput("te_valid", 64'(time_error_valid), 64'(!drop));
    if (!drop) checkOutput("time_error", 64'(time_error), 64'(exp_err));
    checkOutput("set_valid", 64'(set_valid), 64'(!drop && renew));
    if (!drop && renew) checkOutput("set_time", set_time, ct2 + diff);
    checkOutput("adj_valid", 64'(adjust_valid), 64'(adj));
    if (adj) checkOutput("adj_sign", 64'(adjust_sign), 64'(sd < 0));

    if (adj && abort_reset) begin
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      drop_model = 0;
      checkOutput("rst_adj_valid", 64'(adjust_valid), 64'd0);
      checkOutput("rst_time_error", 64'(time_error), 64'd0);
      checkOutput("rst_drop_count", 64'(drop_count), 64'd0);
    end else if (adj) begin
      hs  = 0;
      gap = 1'b0;
      for (int c = 0; c < 400 && hs < n; c++) begin
        was_valid = adjust_valid;
        if (!adjust_valid) gap = 1'b1;
        adjust_ready = 1'($urandom_range(0, 1));
        if (c == 0 && busy) begin
          cmd_rx_start = 1'b1;
          drop_model++;
        end
        if (was_valid && adjust_ready) hs++;
        step();
      end
      checkOutput("adj_handshakes", 64'(hs), 64'(n));
      checkOutput("adj_held", 64'(gap), 64'd0);
      checkOutput("adj_release", 64'(adjust_valid), 64'd0);
    end
    step();
    checkOutput("drop_count", 64'(drop_count), 64'(drop_model));
    step();
  endtask

  initial begin
    int          node, plen;
    logic [63:0] ts, base;
    logic [31:0] off;
    logic [7:0]  cmd;
    longint      delta;

    reset = 1'b1;
    node_id = 8'd0;
    current_time = '0;
    cmd_rx_length = '0;
    cmd_payload_pos = '0;
    cmd_payload_data = '0;
    step();
    step();
    reset = 1'b0;
    $display("[TB] reset state");
    checkOutput("rst_set_valid", 64'(set_valid), 64'd0);
    checkOutput("rst_adjust_valid", 64'(adjust_valid), 64'd0);
    checkOutput("rst_te_valid", 64'(time_error_valid), 64'd0);
    checkOutput("rst_time_error", 64'(time_error), 64'd0);
    checkOutput("rst_drop_count", 64'(drop_count), 64'd0);
    checkOutput("rst_set_time", set_time, 64'd0);
    checkOutput("rst_adjust_sign", 64'(adjust_sign), 64'd0);

    $display("[TB] directed scenarios");
    applyStimulus(1, 8'h02, 64'd1000, 32'd50, 16, 0, 64'd900, 64'd1200, 0, 0, 0);
    applyStimulus(0, 8'h01, 64'd1000, 32'd0, 12, 0, 64'd1025, 64'd77, 0, 0, 0);
    applyStimulus(0, 8'h01, 64'd1000, 32'd0, 12, 0, 64'd980, 64'd5, 0, 0, 0);
    applyStimulus(0, 8'h02, 64'd1000, 32'd0, 12, 1, 64'd980, 64'd5, 0, 0, 0);
    applyStimulus(1, 8'h02, 64'd1000, 32'd0, 12, 0, 64'd980, 64'd5, 0, 0, 0);
    applyStimulus(1, 8'h01, 64'd5000, 32'hFF00_0003, 16, 0, 64'd5020, 64'd9, 1, 1, 0);
    applyStimulus(0, 8'h03, 64'd7000, 32'd0, 12, 0, 64'd6900, 64'd50, 0, 1, 0);
    applyStimulus(0, 8'h01, 64'd1000, 32'd0, 12, 0, 64'd1040, 64'd3, 0, 0, 1);
    applyStimulus(0, 8'h01, 64'd1000, 32'd0, 12, 0, 64'd1020, 64'd3, 0, 0, 0);
    applyStimulus(0, 8'h02, (64'd1 << 40) + 64'd980, 32'd0, 12, 0, 64'd1000,
                  64'd123456, 0, 0, 0);
    applyStimulus(0, 8'hFC, 64'd1000, 32'd0, 12, 0, 64'd1000, 64'd1, 0, 0, 0);

    $display("[TB] randomized packets");
    for (int t = 0; t < 40; t++) begin
      node = ($urandom_range(0, 5) == 0) ? 2 : int'($urandom_range(0, 1));
      plen = 12 + 4 * node + int'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) plen = 12 + 4 * node - 1;
      cmd  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) cmd[1:0] = 2'b00;
      ts   = {$urandom, $urandom};
      off  = $urandom;
      base = ts + {40'd0, off[23:0]} + 64'(LATENCY);
      if ($urandom_range(0, 3) == 0) delta = longint'({$urandom, $urandom});
      else                           delta = longint'($urandom_range(0, 60)) - 30;
      applyStimulus(node, cmd, ts, off, plen, ($urandom_range(0, 7) == 0),
                    base - 64'(delta), {$urandom, $urandom},
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), 0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
